// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, rate
// defaults and the frame-length derivation used to time one serial frame.
package uart_pkg;

    localparam int BAUD_RATE_DEFAULT       = 10000;
    localparam int CLOCK_FREQUENCY_DEFAULT = 250000;
    localparam int TIMER_WIDTH             = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    function automatic int cycles_per_sample(input int baud, input int clk_hz);
        return clk_hz / baud;
    endfunction

    // Ten bit times plus two cycles for the transmitter's input registers.
    function automatic logic [TIMER_WIDTH-1:0] frame_cycles(input int baud, input int clk_hz);
        return TIMER_WIDTH'(10 * cycles_per_sample(baud, clk_hz) + 2);
    endfunction

    localparam int CYCLES_PER_SAMPLE = cycles_per_sample(BAUD_RATE_DEFAULT, CLOCK_FREQUENCY_DEFAULT);
    localparam int FRAME_CYCLES      = 10 * CYCLES_PER_SAMPLE + 2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if;
    logic [1:0] i_req;
    logic [7:0] i_data0;
    logic [7:0] i_data1;
    logic [1:0] o_ack;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;

    modport master (
        output i_req, i_data0, i_data1,
        input  o_ack, o_tx_data, o_tx_start, o_busy
    );

    modport slave (
        input  i_req, i_data0, i_data1,
        output o_ack, o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/uart_frame_timer.sv
// Loadable down-counter that measures one frame; saturates at zero so it
// can never wrap between reloads.
module uart_frame_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] count_r;

    // Counter register: reload has priority over count-down.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (i_load) begin
            count_r <= i_load_value;
        end else if (i_dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign o_done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter, one frame at a time.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int BAUD_RATE       = BAUD_RATE_DEFAULT,
    parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              i_reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam logic [TIMER_WIDTH-1:0] FRAME_LOAD =
        frame_cycles(BAUD_RATE, CLOCK_FREQUENCY) - TIMER_WIDTH'(1);

    arb_state_t state_r;
    logic [1:0] ack_r;
    logic       tx_start_r;
    logic       busy_r;
    logic [7:0] tx_data_r;

    logic       winner_s;
    logic [7:0] winner_data_s;
    logic       timer_load_s;
    logic       timer_dec_s;
    logic       timer_done_s;

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic       last_grant_r;

    // Winner selection: on contention, favour the requester not served last.
    always_comb begin
        winner_s = 1'b0;
        case (bus.i_req)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = ~last_grant_r;
            default: winner_s = 1'b0;
        endcase
    end

    // Last-grant pointer, reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            last_grant_r <= 1'b1;
        end else if ((state_r == IDLE) && (bus.i_req != 2'b00)) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Winner selection: requester 0 always has priority.
    always_comb begin
        winner_s = 1'b0;
        if (bus.i_req[0]) begin
            winner_s = 1'b0;
        end else if (bus.i_req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end
`endif

    assign winner_data_s = winner_s ? bus.i_data1 : bus.i_data0;
    assign timer_load_s  = (state_r == LAUNCH);
    assign timer_dec_s   = (state_r == WAIT);

    uart_frame_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_frame_timer (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_load       (timer_load_s),
        .i_load_value (FRAME_LOAD),
        .i_dec        (timer_dec_s),
        .o_done       (timer_done_s)
    );

    // Arbiter FSM; ack/start are set on the capture edge so they are high
    // exactly during the LAUNCH cycle.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r    <= IDLE;
            ack_r      <= 2'b00;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            tx_data_r  <= 8'hFF;
        end else begin
            ack_r      <= 2'b00;
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.i_req != 2'b00) begin
                        tx_data_r  <= winner_data_s;
                        ack_r      <= winner_s ? 2'b10 : 2'b01;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= LAUNCH;
                    end else begin
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                LAUNCH: begin
                    busy_r  <= 1'b1;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (timer_done_s) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ack      = ack_r;
    assign bus.o_tx_start = tx_start_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter at default rates
// (25 cycles per bit, 252-cycle frame wait).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic i_reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [1:0] exp_ack  [4];
    logic [7:0] exp_data [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .BAUD_RATE       (10000),
        .CLOCK_FREQUENCY (250000)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.o_busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic wait_start(input string tag, output int at);
        int n;
        n = 0;
        while (bus.o_tx_start !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.o_tx_start}, 32'd1);
        at = cyc;
    endtask

    initial begin
        int busy_n;
        int stray;
        int hold_bad;
        int t_prev;
        int t_now;

`ifdef UART_ARB_ROUND_ROBIN_EN
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
        exp_data[0] = 8'h0A; exp_data[1] = 8'h0B; exp_data[2] = 8'h0A; exp_data[3] = 8'h0B;
`else
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b01; exp_ack[2] = 2'b01; exp_ack[3] = 2'b01;
        exp_data[0] = 8'h0A; exp_data[1] = 8'h0A; exp_data[2] = 8'h0A; exp_data[3] = 8'h0A;
`endif

        // Reset state
        i_reset     = 1'b1;
        bus.i_req   = 2'b00;
        bus.i_data0 = 8'h00;
        bus.i_data1 = 8'h00;
        repeat (3) tick();
        check("rst_busy",  {31'd0, bus.o_busy},     32'd0);
        check("rst_start", {31'd0, bus.o_tx_start}, 32'd0);
        check("rst_ack",   {30'd0, bus.o_ack},      32'd0);
        check("rst_data",  {24'd0, bus.o_tx_data},  32'hFF);
        i_reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, bus.o_busy}, 32'd0);

        // Single frame: one-cycle latency, 253 busy cycles, data held
        bus.i_req   = 2'b01;
        bus.i_data0 = 8'hA5;
        tick();
        check("t1_ack",   {30'd0, bus.o_ack},      32'd1);
        check("t1_start", {31'd0, bus.o_tx_start}, 32'd1);
        check("t1_busy",  {31'd0, bus.o_busy},     32'd1);
        check("t1_data",  {24'd0, bus.o_tx_data},  32'hA5);
        bus.i_req = 2'b00;
        busy_n   = 1;
        stray    = 0;
        hold_bad = 0;
        for (int k = 0; k < 400 && bus.o_busy === 1'b1; k++) begin
            if (k == 20) bus.i_data0 = 8'h3C;
            tick();
            if (bus.o_busy === 1'b1) begin
                busy_n++;
                if (bus.o_ack !== 2'b00 || bus.o_tx_start !== 1'b0) stray++;
                if (bus.o_tx_data !== 8'hA5) hold_bad++;
            end
        end
        check("t1_busy_len", busy_n,   32'd253);
        check("t1_stray",    stray,    32'd0);
        check("t1_hold",     hold_bad, 32'd0);
        check("t1_idle",     {31'd0, bus.o_busy},    32'd0);
        check("t1_keep",     {24'd0, bus.o_tx_data}, 32'hA5);

        // Request raised during WAIT waits for IDLE
        bus.i_req   = 2'b01;
        bus.i_data0 = 8'h11;
        tick();
        check("t2_ack0", {30'd0, bus.o_ack}, 32'd1);
        bus.i_req = 2'b00;
        repeat (60) tick();
        bus.i_req   = 2'b10;
        bus.i_data1 = 8'hC3;
        wait_idle("t2_idle");
        check("t2_no_early_ack", {30'd0, bus.o_ack},     32'd0);
        check("t2_data_kept",    {24'd0, bus.o_tx_data}, 32'h11);
        tick();
        check("t2_ack1",   {30'd0, bus.o_ack},      32'd2);
        check("t2_start",  {31'd0, bus.o_tx_start}, 32'd1);
        check("t2_data1",  {24'd0, bus.o_tx_data},  32'hC3);
        bus.i_req = 2'b00;
        wait_idle("t2_done");

        // Continuous contention: grant order and 254-cycle spacing
        bus.i_req   = 2'b11;
        bus.i_data0 = 8'h0A;
        bus.i_data1 = 8'h0B;
        wait_start("t3_start0", t_prev);
        check("t3_ack0",  {30'd0, bus.o_ack},     {30'd0, exp_ack[0]});
        check("t3_data0", {24'd0, bus.o_tx_data}, {24'd0, exp_data[0]});
        for (int g = 1; g < 4; g++) begin
            tick();
            wait_start("t3_start", t_now);
            check("t3_ack",     {30'd0, bus.o_ack},     {30'd0, exp_ack[g]});
            check("t3_data",    {24'd0, bus.o_tx_data}, {24'd0, exp_data[g]});
            check("t3_spacing", t_now - t_prev,         32'd254);
            t_prev = t_now;
        end
        bus.i_req = 2'b00;
        wait_idle("t3_done");

        // Reset mid-frame aborts; pending request granted after release
        bus.i_req   = 2'b01;
        bus.i_data0 = 8'h5A;
        tick();
        check("t4_ack0", {30'd0, bus.o_ack}, 32'd1);
        bus.i_req = 2'b00;
        repeat (30) tick();
        bus.i_req   = 2'b10;
        bus.i_data1 = 8'h77;
        repeat (9) tick();
        check("t4_midframe", {31'd0, bus.o_busy}, 32'd1);
        i_reset = 1'b1;
        tick();
        check("t4_rst_busy",  {31'd0, bus.o_busy},     32'd0);
        check("t4_rst_data",  {24'd0, bus.o_tx_data},  32'hFF);
        check("t4_rst_ack",   {30'd0, bus.o_ack},      32'd0);
        check("t4_rst_start", {31'd0, bus.o_tx_start}, 32'd0);
        i_reset = 1'b0;
        tick();
        check("t4_ack1",  {30'd0, bus.o_ack},      32'd2);
        check("t4_start", {31'd0, bus.o_tx_start}, 32'd1);
        check("t4_data",  {24'd0, bus.o_tx_data},  32'h77);
        bus.i_req = 2'b00;
        wait_idle("t4_done");

        // After a grant to 0, reset restores requester 0 as first winner
        bus.i_req   = 2'b01;
        bus.i_data0 = 8'h42;
        tick();
        check("t5_ack0", {30'd0, bus.o_ack}, 32'd1);
        bus.i_req = 2'b00;
        wait_idle("t5_idle");
        i_reset = 1'b1;
        tick();
        i_reset     = 1'b0;
        bus.i_req   = 2'b11;
        bus.i_data0 = 8'hE1;
        bus.i_data1 = 8'hE2;
        tick();
        check("t5_ptr_ack",  {30'd0, bus.o_ack},     32'd1);
        check("t5_ptr_data", {24'd0, bus.o_tx_data}, 32'hE1);
        bus.i_req = 2'b00;
        wait_idle("t5_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
